ddr_serializer_tx: RTL and testbench
====================================

// Module: ddr_serializer_tx
// PURPOSE
//  Transmit end of the dual-edge (DDR) single-wire link whose receiver samples on both clk edges.
//  Accepts parallel words via valid/ready and serializes 2 bits per clk cycle, MSB first: one bit in the high phase, one in the low phase.
//  Output is glitch-free: XOR of one posedge flop and one negedge flop. ddr_frame marks the first bit pair of each word.
// PARAMETERS
//  WIDTH       8   word width; even, >=2; WIDTH/2 clk cycles per word
//  IDLE_LEVEL  1'b0 line level in both phases when no word is being sent
// PORTS
//  clk        in   1      single clock; posedge and negedge both used internally
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      in_data holds a word to send
//  in_data    in   WIDTH  word; bit WIDTH-1 sent first
//  in_ready   out  1      block accepts in_data this cycle
//  ddr_out    out  1      serial line; = p ^ n (combinational XOR of the two flops)
//  ddr_frame  out  1      high for the clk cycle carrying bits WIDTH-1/WIDTH-2 of a word
//  busy       out  1      high while a word is shifting (state SHIFT)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, shift reg=0, pair counter=0, p=0, n=0 -> ddr_out=0;
//   in_ready=0 while rst=1, ddr_frame=0, busy=0. A word in flight is dropped, never resumed.
//  After rst release: first posedge drives IDLE_LEVEL; in_ready=1 from that posedge.
//  Handshake: transfer when in_valid && in_ready at posedge. in_ready is combinational on state/counter only,
//   never on in_valid. in_ready=1 in IDLE, and in SHIFT only during the last pair cycle (cnt==WIDTH/2-1).
//  FSM (posedge): IDLE --accept--> SHIFT (cnt=0, sreg=in_data);
//   SHIFT, cnt<WIDTH/2-1: cnt++, sreg<<=2.
//   SHIFT, last pair: on accept, reload sreg, cnt=0, stay SHIFT; else go to IDLE.
//  Bit staging (posedge): pos_bit=sreg[WIDTH-1], neg_bit=sreg[WIDTH-2] in SHIFT; both=IDLE_LEVEL in IDLE.
//  Line encoder: posedge: p <= pos_bit ^ n.   negedge: n <= neg_bit_q ^ p.
//   neg_bit_q is neg_bit registered at posedge (half-cycle path into the negedge flop).
//   Result: ddr_out=pos bit for the high phase, neg bit for the low phase of the same cycle.
//  Latency: word accepted at posedge k -> its MSB appears on ddr_out in the high phase after posedge k+1.
//   The word occupies cycles k+1 .. k+WIDTH/2. ddr_frame is registered and aligned to cycle k+1.
//  Back-to-back: accepting on the last pair gives zero idle bits between words; ddr_frame pulses every WIDTH/2 cycles.
//  in_valid dropped mid-word: no effect; the current word completes, then the line goes to IDLE_LEVEL.
//  in_data changes while not accepted: ignored. Captured only at the handshake.
//  WIDTH==2: every cycle is both first and last pair; ddr_frame stays 1 during continuous streaming.
// STRUCTURE
//  Package ddr_link_pkg: state enum {IDLE, SHIFT}; IDLE_LEVEL default; function pairs(WIDTH)=WIDTH/2;
//   the same package is shared with the DDR receiver.
//  Sub-module ddr_xor_oddr (clk, rst, pos_bit, neg_bit, q): holds the p/n flop pair and the XOR. Reusable for other DDR outputs.
//  Top level: FSM, pair counter ($clog2(WIDTH/2), min 1 bit), shift reg, frame flop.
//  Elaboration check: error if WIDTH is odd or <2.
// TESTING
//  1 Reset: hold rst, toggle clk -> ddr_out=0, in_ready=0, busy=0.
//    Release -> ddr_out=IDLE_LEVEL both phases, in_ready=1.
//  2 Single word WIDTH=8, in_data=8'hA5, one-cycle valid -> ddr_out phases 1,0|1,0|0,1|0,1 over 4 cycles.
//    ddr_frame=1 only in the first of those cycles; busy high for 4 cycles, then line at IDLE_LEVEL.
//  3 Back-to-back 8'hFF, 8'h00, 8'h3C with valid held -> 24 contiguous bits, no gap; ddr_frame every 4th cycle;
//    in_ready high only in the last pair cycle of each word.
//  4 Async rst asserted mid-phase while sending 8'hC3 (after 3 bits) -> ddr_out=0 immediately.
//    After release: line at IDLE_LEVEL; the next word 8'h81 is sent intact.
//  5 Glitch check: IDLE_LEVEL=1, stream 8'h55 -> ddr_out toggles once per phase, with no extra edges near either clk edge (gate-level/SDF).
//  6 Loopback to the DDR receiver with random words and random valid gaps -> every received word equals its sent word, in order.

Source files
------------

// File: rtl/ddr_link_pkg.sv
// Shared definitions for the single-wire DDR link (transmitter and receiver).
package ddr_link_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    function automatic int unsigned pairs(input int unsigned width);
        return width / 2;
    endfunction

endpackage

// File: rtl/ddr_xor_oddr.sv
// Glitch-free DDR output: ddr bit = posedge flop XOR negedge flop, so only one flop
// toggles per clock phase.
module ddr_xor_oddr (
    input  logic clk,
    input  logic rst,
    input  logic pos_bit,
    input  logic neg_bit,
    output logic q
);

    logic p_q;
    logic p_d;
    logic n_q;
    logic n_d;
    logic neg_bit_q;

    always_comb begin
        p_d = pos_bit ^ n_q;
        n_d = neg_bit_q ^ p_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q       <= 1'b0;
            neg_bit_q <= 1'b0;
        end else begin
            p_q       <= p_d;
            neg_bit_q <= neg_bit;
        end
    end

    // neg_bit_q to n_q is a half-cycle path into the falling-edge flop
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            n_q <= 1'b0;
        end else begin
            n_q <= n_d;
        end
    end

    assign q = p_q ^ n_q;

endmodule

// File: rtl/ddr_serializer_tx.sv
// DDR link transmitter: takes WIDTH-bit words over valid/ready and sends two bits per
// clk cycle, MSB first, high-phase bit then low-phase bit.
module ddr_serializer_tx
    import ddr_link_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ddr_out,
    output logic             ddr_frame,
    output logic             busy
);

    localparam int unsigned   PAIRS = pairs(WIDTH);
    localparam int unsigned   CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0] LAST  = CW'(PAIRS - 1);

    if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_width_check
        $error("ddr_serializer_tx: WIDTH must be even and >= 2");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             frame_q;
    logic             frame_d;
    logic             accept;
    logic             pos_bit;
    logic             neg_bit;

    // Ready depends only on state/counter so upstream can wait on it without a loop
    always_comb begin
        in_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST)));
    end

    always_comb begin
        accept  = in_valid && in_ready;
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        frame_d = (state_q == SHIFT) && (cnt_q == '0);
        pos_bit = IDLE_LEVEL;
        neg_bit = IDLE_LEVEL;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sreg_d  = in_data;
                end
            end
            SHIFT: begin
                pos_bit = sreg_q[WIDTH-1];
                neg_bit = sreg_q[WIDTH-2];
                if (cnt_q != LAST) begin
                    cnt_d  = cnt_q + 1'b1;
                    sreg_d = sreg_q << 2;
                end else if (accept) begin
                    cnt_d  = '0;
                    sreg_d = in_data;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            frame_q <= frame_d;
        end
    end

    ddr_xor_oddr u_oddr (
        .clk     (clk),
        .rst     (rst),
        .pos_bit (pos_bit),
        .neg_bit (neg_bit),
        .q       (ddr_out)
    );

    assign ddr_frame = frame_q;
    assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_ddr_serializer_tx.sv
// Bench for ddr_serializer_tx: a WIDTH=8/IDLE=0 and a WIDTH=2/IDLE=1 instance against a
// pair-FIFO line model, plus an in-bench receiver that reassembles words from the line.
module tb_ddr_serializer_tx;

    typedef struct packed {
        logic pos;
        logic neg;
        logic first;
    } pair_t;

    localparam logic IDLE_A = 1'b0;
    localparam logic IDLE_B = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid_a = 1'b0;
    logic [7:0] in_data_a = '0;
    logic       in_ready_a, ddr_out_a, ddr_frame_a, busy_a;
    logic       in_valid_b = 1'b0;
    logic [1:0] in_data_b = '0;
    logic       in_ready_b, ddr_out_b, ddr_frame_b, busy_b;

    ddr_serializer_tx #(.WIDTH(8), .IDLE_LEVEL(IDLE_A)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a),
        .in_data   (in_data_a),
        .in_ready  (in_ready_a),
        .ddr_out   (ddr_out_a),
        .ddr_frame (ddr_frame_a),
        .busy      (busy_a)
    );

    ddr_serializer_tx #(.WIDTH(2), .IDLE_LEVEL(IDLE_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_b),
        .in_data   (in_data_b),
        .in_ready  (in_ready_b),
        .ddr_out   (ddr_out_b),
        .ddr_frame (ddr_frame_b),
        .busy      (busy_b)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    pair_t      fa[$];
    pair_t      fb[$];
    pair_t      la = '0;
    pair_t      lb = '0;
    logic [7:0] qa[$];
    logic [7:0] sent_a[$];
    logic [1:0] qb[$];
    logic [7:0] rx_word = '0;
    int         rx_cnt = 0;
    bit         rx_on = 1'b0;
    int         edges_b = 0;
    int         edges_seen = 0;
    logic       prev_b = 1'b0;
    bit         edge_chk = 1'b0;

    always @(ddr_out_b) edges_b++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One line edge per phase when the expected level changes, none otherwise
    task automatic edge_sample(input logic exp);
        if (edge_chk) chk("edges_b", edges_b - edges_seen, (exp !== prev_b) ? 1 : 0);
        edges_seen = edges_b;
        prev_b     = exp;
        edge_chk   = 1'b1;
    endtask

    task automatic rx_bit(input logic b);
        if (!rx_on) return;
        rx_word = {rx_word[6:0], b};
        rx_cnt++;
        if (rx_cnt == 8) begin
            rx_on = 1'b0;
            if (sent_a.size() > 0) chk("loopback_a", rx_word, sent_a.pop_front());
            else chk("loopback_extra_a", rx_word, 'x);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_a"}, ddr_out_a, 1'b0);
        chk({tag, "_out_b"}, ddr_out_b, 1'b0);
        chk({tag, "_ready_a"}, in_ready_a, 1'b0);
        chk({tag, "_ready_b"}, in_ready_b, 1'b0);
        chk({tag, "_busy_a"}, busy_a, 1'b0);
        chk({tag, "_frame_a"}, ddr_frame_a, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        #1;
        fa.delete();
        fb.delete();
        sent_a.delete();
        la       = '0;
        lb       = '0;
        rx_on    = 1'b0;
        edge_chk = 1'b0;
        check_reset_outputs("rst_async");
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_reset_outputs("rst_hi");
            @(negedge clk); #1;
            chk("rst_lo_a", ddr_out_a, 1'b0);
            chk("rst_lo_b", ddr_out_b, 1'b0);
        end
        rst = 1'b0;
    endtask

    // One clk cycle: drive in the low phase, check both phases after the posedge
    task automatic cycle(input bit gaps);
        logic       va, vb, acc_a, acc_b;
        logic [7:0] wa;
        logic [1:0] wb;
        va         = (qa.size() > 0) && !(gaps && ($urandom_range(0, 3) == 0));
        vb         = (qb.size() > 0) && !(gaps && ($urandom_range(0, 3) == 0));
        in_valid_a = va;
        in_data_a  = va ? qa[0] : 8'($urandom);
        in_valid_b = vb;
        in_data_b  = vb ? qb[0] : 2'($urandom);
        acc_a      = va && (fa.size() <= 1);
        acc_b      = vb && (fb.size() <= 1);
        @(posedge clk);
        if (fa.size() > 0) la = fa.pop_front();
        else la = {IDLE_A, IDLE_A, 1'b0};
        if (fb.size() > 0) lb = fb.pop_front();
        else lb = {IDLE_B, IDLE_B, 1'b0};
        if (acc_a) begin
            wa = qa.pop_front();
            sent_a.push_back(wa);
            for (int i = 0; i < 4; i++) fa.push_back({wa[7-2*i], wa[6-2*i], (i == 0)});
        end
        if (acc_b) begin
            wb = qb.pop_front();
            fb.push_back({wb[1], wb[0], 1'b1});
        end
        #1;
        chk("hi_a", ddr_out_a, la.pos);
        chk("frame_a", ddr_frame_a, la.first);
        chk("busy_a", busy_a, fa.size() > 0);
        chk("ready_a", in_ready_a, fa.size() <= 1);
        chk("hi_b", ddr_out_b, lb.pos);
        chk("frame_b", ddr_frame_b, lb.first);
        chk("busy_b", busy_b, fb.size() > 0);
        chk("ready_b", in_ready_b, fb.size() <= 1);
        edge_sample(lb.pos);
        if (ddr_frame_a) begin
            rx_on   = 1'b1;
            rx_cnt  = 0;
            rx_word = '0;
        end
        rx_bit(ddr_out_a);
        @(negedge clk); #1;
        chk("lo_a", ddr_out_a, la.neg);
        chk("lo_b", ddr_out_b, lb.neg);
        edge_sample(lb.neg);
        rx_bit(ddr_out_a);
    endtask

    initial begin
        #2;
        // reset and idle line after release
        do_reset(3);
        repeat (2) cycle(1'b0);

        // single word, one-cycle valid
        qa.push_back(8'hA5);
        repeat (7) cycle(1'b0);

        // back-to-back words with valid held
        qa.push_back(8'hFF);
        qa.push_back(8'h00);
        qa.push_back(8'h3C);
        repeat (15) cycle(1'b0);

        // async reset in the low phase of the second pair, then a clean word
        qa.push_back(8'hC3);
        repeat (2) cycle(1'b0);
        @(posedge clk);
        @(negedge clk); #2;
        do_reset(2);
        cycle(1'b0);
        qa.push_back(8'h81);
        repeat (6) cycle(1'b0);

        // IDLE_LEVEL=1 stream toggling every phase
        repeat (12) qb.push_back(2'b01);
        repeat (14) cycle(1'b0);

        // random words and random valid gaps on both instances
        for (int i = 0; i < 300; i++) begin
            if ((qa.size() < 2) && ($urandom_range(0, 1) == 1)) qa.push_back(8'($urandom));
            if ((qb.size() < 2) && ($urandom_range(0, 1) == 1)) qb.push_back(2'($urandom));
            cycle(1'b1);
        end
        repeat (12) cycle(1'b0);
        chk("words_undelivered_a", sent_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
